// File: rtl/smg_digit_encoder.sv
// Splits a 0..99 binary value into tens/ones by repeated subtraction of 10 and
// drives registered active-low seven-segment patterns for the row scan stage.
module smg_digit_encoder #(
    parameter bit         BLANK_LZ    = 1'b1,
    parameter logic [7:0] ERR_PATTERN = 8'hBF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] Number_Data,
    input  logic       Load_Sig,
    output logic [7:0] Ten_SMG_Data,
    output logic [7:0] One_SMG_Data,
    output logic       Busy_Sig,
    output logic       Done_Sig
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV    = 2'd1,
        ENCODE = 2'd2
    } state_e;

    state_e     state_q;
    logic [6:0] rem_q;
    logic [3:0] tens_q;
    logic       err_q;
    logic [7:0] ten_q;
    logic [7:0] one_q;
    logic       busy_q;
    logic       done_q;

    logic [7:0] ten_seg_d;
    logic [7:0] one_seg_d;

    // {dp,g,f,e,d,c,b,a}, a segment is lit when its bit is 0.
    function automatic logic [7:0] seg_of(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    always_comb begin
        // NOTE: every output of this block is assigned up front so no path can infer a latch.
        ten_seg_d = ERR_PATTERN;
        one_seg_d = ERR_PATTERN;
        if (!err_q) begin
            ten_seg_d = (BLANK_LZ && (tens_q == 4'd0)) ? 8'hFF : seg_of(tens_q);
            one_seg_d = seg_of(rem_q[3:0]);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            rem_q   <= 7'd0;
            tens_q  <= 4'd0;
            err_q   <= 1'b0;
            ten_q   <= 8'hFF;
            one_q   <= 8'hFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Load_Sig) begin
                        rem_q  <= Number_Data;
                        tens_q <= 4'd0;
                        busy_q <= 1'b1;
                        if (Number_Data > 7'd99) begin
                            err_q   <= 1'b1;
                            state_q <= ENCODE;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (rem_q >= 7'd10) begin
                        rem_q  <= rem_q - 7'd10;
                        tens_q <= tens_q + 4'd1;
                    end else begin
                        state_q <= ENCODE;
                    end
                end
                ENCODE: begin
                    // Displayed digits only ever change here, so the scan stage never sees partials.
                    ten_q   <= ten_seg_d;
                    one_q   <= one_seg_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Ten_SMG_Data = ten_q;
    assign One_SMG_Data = one_q;
    assign Busy_Sig     = busy_q;
    assign Done_Sig     = done_q;

endmodule

// File: tb/tb_smg_digit_encoder.sv
// Scoreboard bench for smg_digit_encoder: one instance per leading-zero mode,
// expected segments and completion cycle queued at load time, popped on Done_Sig.
module tb_smg_digit_encoder;

    logic       CLK = 1'b0;
    logic       RST;
    logic [6:0] Number_Data;
    logic       Load_Sig;
    logic [7:0] ten_seg, one_seg, ten_nb, one_nb;
    logic       busy, done, busy_nb, done_nb;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int nbusy;

    typedef struct {
        logic [7:0] ten;
        logic [7:0] one;
        logic [7:0] ten_nb;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    smg_digit_encoder #(.BLANK_LZ(1'b1), .ERR_PATTERN(8'hBF)) dut (
        .CLK(CLK), .RST(RST), .Number_Data(Number_Data), .Load_Sig(Load_Sig),
        .Ten_SMG_Data(ten_seg), .One_SMG_Data(one_seg), .Busy_Sig(busy), .Done_Sig(done)
    );

    smg_digit_encoder #(.BLANK_LZ(1'b0), .ERR_PATTERN(8'hBF)) dut_nb (
        .CLK(CLK), .RST(RST), .Number_Data(Number_Data), .Load_Sig(Load_Sig),
        .Ten_SMG_Data(ten_nb), .One_SMG_Data(one_nb), .Busy_Sig(busy_nb), .Done_Sig(done_nb)
    );

    always #10 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] seg_model(input int d);
        logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return tbl[d];
    endfunction

    // Called at a negedge; the following posedge is the load edge.
    task automatic load(input int v);
        exp_t e;
        int   t;
        if (v > 99) begin
            e.ten    = 8'hBF;
            e.one    = 8'hBF;
            e.ten_nb = 8'hBF;
            e.cyc    = cyc + 1 + 1;
        end else begin
            t        = v / 10;
            e.ten    = (t == 0) ? 8'hFF : seg_model(t);
            e.ten_nb = seg_model(t);
            e.one    = seg_model(v % 10);
            e.cyc    = cyc + 1 + t + 2;
        end
        sb_q.push_back(e);
        Number_Data = 7'(v);
        Load_Sig    = 1'b1;
        @(negedge CLK);
        Load_Sig    = 1'b0;
    endtask

    task automatic wait_done(input int max, output int nb);
        bit seen = 1'b0;
        nb = 0;
        for (int i = 0; i < max && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nb++;
                @(negedge CLK);
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge CLK) begin
        if (!RST && (done || done_nb)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("ten", ten_seg, mon_e.ten);
                check("one", one_seg, mon_e.one);
                check("ten_nolz", ten_nb, mon_e.ten_nb);
                check("one_nolz", one_nb, mon_e.one);
                check("done_pair", done_nb, done);
                check("busy_in_done", busy, 32'd0);
            end
        end
    end

    initial begin
        RST         = 1'b1;
        Load_Sig    = 1'b0;
        Number_Data = 7'd0;
        repeat (3) @(negedge CLK);
        check("rst_ten", ten_seg, 32'hFF);
        check("rst_one", one_seg, 32'hFF);
        check("rst_ten_nolz", ten_nb, 32'hFF);
        check("rst_busy", busy, 32'd0);
        check("rst_done", done, 32'd0);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        check("idle_ten", ten_seg, 32'hFF);
        check("idle_one", one_seg, 32'hFF);
        check("idle_busy", busy, 32'd0);

        load(47);
        wait_done(30, nbusy);
        check("busy_len_47", nbusy, 32'd6);
        repeat (10) @(negedge CLK);
        check("hold_ten", ten_seg, 32'h99);
        check("hold_one", one_seg, 32'hF8);
        check("hold_busy", busy, 32'd0);

        load(5);
        wait_done(30, nbusy);
        check("busy_len_5", nbusy, 32'd2);

        // Two loads of 12 while 99 is converting must be dropped.
        @(negedge CLK);
        load(99);
        repeat (2) @(negedge CLK);
        Number_Data = 7'd12;
        Load_Sig    = 1'b1;
        @(negedge CLK);
        Load_Sig    = 1'b0;
        check("busy_during_99", busy, 32'd1);
        repeat (3) @(negedge CLK);
        Load_Sig    = 1'b1;
        @(negedge CLK);
        Load_Sig    = 1'b0;
        wait_done(30, nbusy);
        load(12);
        wait_done(30, nbusy);

        @(negedge CLK);
        load(100);
        wait_done(30, nbusy);
        load(127);
        wait_done(30, nbusy);
        load(0);
        wait_done(30, nbusy);

        // Reset lands at edge 4 of an 88 conversion.
        @(negedge CLK);
        load(88);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        sb_q.delete();
        check("midrst_ten", ten_seg, 32'hFF);
        check("midrst_one", one_seg, 32'hFF);
        check("midrst_busy", busy, 32'd0);
        check("midrst_done", done, 32'd0);
        RST = 1'b0;
        repeat (12) @(negedge CLK);
        check("post_rst_one", one_seg, 32'hFF);

        load(30);
        wait_done(30, nbusy);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge CLK);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
